// File: rtl/ctrl_pipe_stages.sv
// rtl/ctrl_pipe_stages.sv - EX/MEM and MEM/WB control pipeline with branch/load-use masking
// Optional operand forwarding selects are built only when CTRL_PIPE_FWD_EN is defined.
module ctrl_pipe_stages #(
    parameter int RADDR_W = 5
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               RegWrite_ID_EX,
    input  logic               PCWriteCond_ID_EX,
    input  logic               MemRead_ID_EX,
    input  logic               MemWrite_ID_EX,
    input  logic               MemtoReg_ID_EX,
    input  logic [RADDR_W-1:0] Rd_ID_EX,
    input  logic [RADDR_W-1:0] Rs1_ID_EX,
    input  logic [RADDR_W-1:0] Rs2_ID_EX,
    input  logic [RADDR_W-1:0] Rs1_IF_ID,
    input  logic [RADDR_W-1:0] Rs2_IF_ID,
    input  logic               BrTaken,
    output logic               RegWrite_EX_MEM,
    output logic               MemRead_EX_MEM,
    output logic               MemWrite_EX_MEM,
    output logic               MemtoReg_EX_MEM,
    output logic [RADDR_W-1:0] Rd_EX_MEM,
    output logic               RegWrite_MEM_WB,
    output logic               MemtoReg_MEM_WB,
    output logic [RADDR_W-1:0] Rd_MEM_WB,
    output logic               LoadUseStall,
    output logic               Flush_IF_ID,
    output logic [1:0]         ForwardA,
    output logic [1:0]         ForwardB
);

    logic [1:0] squashCnt;
    logic       bubbleNxt;
    logic       bundleValid;
    logic       loadHit;

    assign bundleValid = (squashCnt == 2'd0) && !bubbleNxt;
    assign Flush_IF_ID = bundleValid & PCWriteCond_ID_EX & BrTaken;
    assign loadHit     = (Rd_ID_EX != '0) &&
                         ((Rd_ID_EX == Rs1_IF_ID) || (Rd_ID_EX == Rs2_IF_ID));
    // A taken branch wins: the stalled instruction is wrong-path anyway.
    assign LoadUseStall = bundleValid & MemRead_ID_EX & loadHit & !Flush_IF_ID;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            squashCnt       <= 2'd0;
            bubbleNxt       <= 1'b0;
            RegWrite_EX_MEM <= 1'b0;
            MemRead_EX_MEM  <= 1'b0;
            MemWrite_EX_MEM <= 1'b0;
            MemtoReg_EX_MEM <= 1'b0;
            Rd_EX_MEM       <= '0;
            RegWrite_MEM_WB <= 1'b0;
            MemtoReg_MEM_WB <= 1'b0;
            Rd_MEM_WB       <= '0;
        end else begin
            if (Flush_IF_ID)
                squashCnt <= 2'd2;
            else if (squashCnt != 2'd0)
                squashCnt <= squashCnt - 2'd1;
            bubbleNxt       <= LoadUseStall;
            // Masked bundles become full NOPs so no stale side effect leaks downstream.
            RegWrite_EX_MEM <= bundleValid & RegWrite_ID_EX;
            MemRead_EX_MEM  <= bundleValid & MemRead_ID_EX;
            MemWrite_EX_MEM <= bundleValid & MemWrite_ID_EX;
            MemtoReg_EX_MEM <= bundleValid & MemtoReg_ID_EX;
            Rd_EX_MEM       <= Rd_ID_EX;
            RegWrite_MEM_WB <= RegWrite_EX_MEM;
            MemtoReg_MEM_WB <= MemtoReg_EX_MEM;
            Rd_MEM_WB       <= Rd_EX_MEM;
        end
    end

`ifdef CTRL_PIPE_FWD_EN
    logic exHitA, exHitB, wbHitA, wbHitB;

    assign exHitA = RegWrite_EX_MEM && (Rd_EX_MEM != '0) && (Rd_EX_MEM == Rs1_ID_EX);
    assign exHitB = RegWrite_EX_MEM && (Rd_EX_MEM != '0) && (Rd_EX_MEM == Rs2_ID_EX);
    assign wbHitA = RegWrite_MEM_WB && (Rd_MEM_WB != '0) && (Rd_MEM_WB == Rs1_ID_EX);
    assign wbHitB = RegWrite_MEM_WB && (Rd_MEM_WB != '0) && (Rd_MEM_WB == Rs2_ID_EX);

    always_comb begin
        ForwardA = 2'b00;
        ForwardB = 2'b00;
        if (exHitA)      ForwardA = 2'b10;
        else if (wbHitA) ForwardA = 2'b01;
        if (exHitB)      ForwardB = 2'b10;
        else if (wbHitB) ForwardB = 2'b01;
    end
`else
    logic unusedRs;
    assign unusedRs = ^{Rs1_ID_EX, Rs2_ID_EX};
    assign ForwardA = 2'b00;
    assign ForwardB = 2'b00;
`endif

endmodule

// File: doc/ctrl_pipe_stages.md
# ctrl_pipe_stages

Downstream consumer of the ID/EX control bundle produced by the decode control unit. Carries the bundle through the EX/MEM and MEM/WB pipeline registers and masks wrong-path and stalled instructions as bubbles. Also generates the load-use stall, the branch flush and, optionally, the operand-forwarding selects. Sits between the decode control unit and the EX/MEM/WB datapath registers of the 5-stage RV32I core.

## Interface
Parameters:
- RADDR_W, 5, register-index width.

Ports:
- CLK  in  1  core clock; all state updates on rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- RegWrite_ID_EX, PCWriteCond_ID_EX, MemRead_ID_EX, MemWrite_ID_EX, MemtoReg_ID_EX  in  1 each  raw ID/EX control bundle from decode.
- Rd_ID_EX, Rs1_ID_EX, Rs2_ID_EX  in  RADDR_W  register indices of the instruction in EX.
- Rs1_IF_ID, Rs2_IF_ID  in  RADDR_W  source indices of the instruction in ID.
- BrTaken  in  1  EX-stage branch comparison result.
- RegWrite_EX_MEM, MemRead_EX_MEM, MemWrite_EX_MEM, MemtoReg_EX_MEM  out  1 each  EX/MEM control.
- Rd_EX_MEM  out  RADDR_W  EX/MEM destination.
- RegWrite_MEM_WB, MemtoReg_MEM_WB  out  1 each  MEM/WB control.
- Rd_MEM_WB  out  RADDR_W  MEM/WB destination.
- LoadUseStall  out  1  hold PC and IF/ID this cycle.
- Flush_IF_ID  out  1  redirect PC to the branch target.
- ForwardA, ForwardB  out  2  operand select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.

## Operation
- Effective valid: `v = (squash_cnt == 0) && !bubble_nxt`. If `v = 0`, RegWrite, PCWriteCond, MemRead and MemWrite of the incoming bundle are treated as 0.
- **Branch.**
  - `Flush_IF_ID = v & PCWriteCond_ID_EX & BrTaken`, combinational.
  - On the edge where Flush_IF_ID = 1, `squash_cnt` is set to 2. Upstream does not clear IF/ID, so the two following ID/EX bundles are wrong-path and are masked.
  - Otherwise `squash_cnt` decrements to 0 and saturates there.
- **Load-use.**
  - `LoadUseStall = v & MemRead_ID_EX & (Rd_ID_EX != 0) & (Rd_ID_EX == Rs1_IF_ID | Rd_ID_EX == Rs2_IF_ID) & !Flush_IF_ID`.
  - On the edge where LoadUseStall = 1, `bubble_nxt` is set for one cycle. Decode re-latches the held instruction, so the first copy is masked and the second copy proceeds.
  - `bubble_nxt` clears on the following edge.
- **Priority.** A taken branch beats load-use. LoadUseStall is never asserted while `v = 0`.
- **Pipeline.** Every edge: EX/MEM ← effective bundle and Rd_ID_EX; MEM/WB ← RegWrite_EX_MEM, MemtoReg_EX_MEM, Rd_EX_MEM. No enable or hold on these registers; stalls are realised only as bubbles.
- **Forwarding** (rule shown for A; B is identical using Rs2_ID_EX):
  - 10 if `RegWrite_EX_MEM & Rd_EX_MEM != 0 & Rd_EX_MEM == Rs1_ID_EX`;
  - else 01 if the same test holds on MEM/WB;
  - else 00.
  - EX/MEM takes priority over MEM/WB.

## Timing
- Reset (RSTn low, asynchronous): all EX/MEM and MEM/WB outputs 0, `squash_cnt` = 0, `bubble_nxt` = 0. LoadUseStall, Flush_IF_ID and ForwardA/B therefore evaluate with zeroed state; ForwardA/B = 00.
- Reset asserted mid-operation discards all in-flight control immediately. The first bundle after release is valid.
- Latency: ID/EX → EX/MEM in 1 cycle; → MEM/WB in 2 cycles.
- LoadUseStall, Flush_IF_ID and ForwardA/B are combinational, valid in the same cycle as their inputs.
- A taken branch in cycle n masks the bundles present in cycles n+1 and n+2.
- A branch arriving while `squash_cnt != 0` is masked and never flushes.

## Configuration
- `CTRL_PIPE_FWD_EN` defined: forwarding logic as described above.
- Not defined:
  - ForwardA/B are tied to 00 and the forwarding comparators are removed.
  - Hazard logic is unchanged.
  - Software must insert NOPs for non-load RAW distances of 1 and 2.

## Test plan
- Reset: drive all inputs to 1 with RSTn=0 → all registered outputs 0 asynchronously, with no clock edge needed; ForwardA/B = 00.
- Propagation: one LW bundle, Rd=5 → cycle+1: MemRead_EX_MEM=1, MemtoReg_EX_MEM=1, Rd_EX_MEM=5; cycle+2: RegWrite_MEM_WB=1, MemtoReg_MEM_WB=1, Rd_MEM_WB=5.
- Taken branch: PCWriteCond=1, BrTaken=1 at cycle n, then ADD bundles (RegWrite=1) at n+1, n+2, n+3 → Flush_IF_ID=1 at n; RegWrite_EX_MEM=0 at n+2 and n+3; RegWrite_EX_MEM=1 at n+4.
- Load-use: LW Rd=3 with Rs1_IF_ID=3 → LoadUseStall=1. The next bundle is masked (EX/MEM all zero) and the following bundle passes.
- Simultaneous: taken branch plus load-use match in the same cycle → Flush_IF_ID=1, LoadUseStall=0, `squash_cnt`=2.
- Forwarding (`CTRL_PIPE_FWD_EN` defined): Rd_EX_MEM=Rd_MEM_WB=7, both with RegWrite=1, Rs1_ID_EX=7 → ForwardA=10. With Rd=0 → ForwardA=00. Macro not defined → always 00.
